// File: rtl/rv32i_pipe_ctrl_pkg.sv
// Shared rv32 pipeline-control types: FSM state encoding and default trap vector.
package rv32i_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEMW  = 2'd2,
    ST_FLUSH = 2'd3
  } pipe_state_e;

  localparam logic [31:0] RV32I_TRAP_VECTOR_DEF = 32'h0000_0040;

endpackage

// File: rtl/rv32i_sat_counter.sv
// Saturating event counter; counts on i_inc and holds at all-ones.
// Latency: 1 cycle, registered; backpressure: none.
module rv32i_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// RV32I hazard / redirect / mem-wait controller; statistics counters exist only with RV32_PIPE_STATS_EN.
// Latency: 1 cycle, all outputs registered; backpressure: stall freezes fetch and decode.
module rv32i_pipe_ctrl
  import rv32i_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RV32I_TRAP_VECTOR = RV32I_TRAP_VECTOR_DEF,
  parameter int          FLUSH_CYCLES      = 2,
  parameter int          MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mem_wait,
  output logic        stall,
  output logic        update_pc,
  output logic [31:0] new_pc,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);
  localparam logic [7:0] MEM_LIMIT  = 8'(MEM_TIMEOUT);

  pipe_state_e r_state, w_state;
  logic [1:0]  r_flush_cnt, w_flush_cnt;
  logic [7:0]  r_memw_cnt, w_memw_cnt, w_memw_run;
  logic        r_pend_vld, w_pend_vld;
  logic [31:0] r_pend_pc, w_pend_pc;
  logic        r_to_block, w_to_block;
  logic        r_stall, w_stall;
  logic        r_update_pc, w_update_pc;
  logic [31:0] r_new_pc, w_new_pc;
  logic        r_mem_timeout, w_mem_timeout;
  logic        w_hazard;
  logic        w_mem_wait;

  assign w_hazard = ex_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // After a timeout, a still-high mem_wait is ignored until it drops once.
  assign w_mem_wait = mem_wait && !r_to_block;
  assign w_memw_run = (r_state == ST_MEMW) ? r_memw_cnt : 8'd0;

  always_comb begin
    w_state       = r_state;
    w_flush_cnt   = r_flush_cnt;
    w_memw_cnt    = 8'd0;
    w_pend_vld    = r_pend_vld;
    w_pend_pc     = r_pend_pc;
    w_to_block    = r_to_block && mem_wait;
    w_stall       = 1'b0;
    w_update_pc   = 1'b0;
    w_new_pc      = r_new_pc;
    w_mem_timeout = 1'b0;

    if (w_mem_wait) begin
      if (w_memw_run == MEM_LIMIT) begin
        w_mem_timeout = 1'b1;
        w_update_pc   = 1'b1;
        w_new_pc      = RV32I_TRAP_VECTOR;
        w_pend_vld    = 1'b0;
        w_state       = ST_FLUSH;
        w_flush_cnt   = FLUSH_INIT;
        w_to_block    = 1'b1;
      end else begin
        w_state    = ST_MEMW;
        w_stall    = 1'b1;
        w_memw_cnt = 8'(w_memw_run + 8'd1);
        if (br_taken && !r_pend_vld) begin
          w_pend_vld = 1'b1;
          w_pend_pc  = br_target;
        end
      end
    end else if (r_pend_vld) begin
      w_update_pc = 1'b1;
      w_new_pc    = r_pend_pc;
      w_pend_vld  = 1'b0;
      w_state     = ST_FLUSH;
      w_flush_cnt = FLUSH_INIT;
    end else if (br_taken) begin
      w_update_pc = 1'b1;
      w_new_pc    = br_target;
      w_state     = ST_FLUSH;
      w_flush_cnt = FLUSH_INIT;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          if (r_flush_cnt <= 2'd1) begin
            w_state = ST_RUN;
          end else begin
            w_flush_cnt = r_flush_cnt - 2'd1;
          end
        end
        ST_RUN: begin
          if (w_hazard) begin
            w_state = ST_HAZ;
            w_stall = 1'b1;
          end
        end
        default: w_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= 2'd0;
      r_memw_cnt    <= 8'd0;
      r_pend_vld    <= 1'b0;
      r_pend_pc     <= 32'd0;
      r_to_block    <= 1'b0;
      r_stall       <= 1'b0;
      r_update_pc   <= 1'b0;
      r_new_pc      <= 32'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_flush_cnt   <= w_flush_cnt;
      r_memw_cnt    <= w_memw_cnt;
      r_pend_vld    <= w_pend_vld;
      r_pend_pc     <= w_pend_pc;
      r_to_block    <= w_to_block;
      r_stall       <= w_stall;
      r_update_pc   <= w_update_pc;
      r_new_pc      <= w_new_pc;
      r_mem_timeout <= w_mem_timeout;
    end
  end

  assign stall       = r_stall;
  assign update_pc   = r_update_pc;
  assign new_pc      = r_new_pc;
  assign mem_timeout = r_mem_timeout;

`ifdef RV32_PIPE_STATS_EN
  // Counters are fed the next-state pulses so they stay aligned with the outputs.
  rv32i_sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_stall),
    .o_cnt (stall_cycles)
  );

  rv32i_sat_counter #(.W(32)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_update_pc),
    .o_cnt (redirect_count)
  );
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: load-use, redirect, mem-wait, timeout, reset and statistics.
module tb_rv32i_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_load, br_taken, mem_wait;
  logic [31:0] br_target;
  logic        stall, update_pc, mem_timeout;
  logic [31:0] new_pc, stall_cycles, redirect_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RV32_PIPE_STATS_EN
  localparam logic [31:0] EXP_STALLS = 32'd10;
  localparam logic [31:0] EXP_REDIR  = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_REDIR  = 32'd0;
`endif

  always #5 clk = ~clk;

  rv32i_pipe_ctrl #(
    .RV32I_TRAP_VECTOR (32'h0000_0040),
    .FLUSH_CYCLES      (2),
    .MEM_TIMEOUT       (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_load        (ex_load),
    .ex_rd          (ex_rd),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .mem_wait       (mem_wait),
    .stall          (stall),
    .update_pc      (update_pc),
    .new_pc         (new_pc),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1    = 5'd0;
    id_rs2    = 5'd0;
    ex_load   = 1'b0;
    ex_rd     = 5'd0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    mem_wait  = 1'b0;
  endtask

  task automatic hazard(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_rs1  = rs1;
    id_rs2  = rs2;
    ex_rd   = rd;
    ex_load = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_upd", {31'd0, update_pc}, 32'd0);
    chk("rst_newpc", new_pc, 32'd0);
    chk("rst_to", {31'd0, mem_timeout}, 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    chk("rst_rc", redirect_count, 32'd0);
    reset = 1'b0;
    step();

    // load-use via rs2, then one-cycle release
    hazard(5'd1, 5'd5, 5'd5);
    step();
    chk("lu_rs2_stall", {31'd0, stall}, 32'd1);
    idle();
    step();
    chk("lu_one_cycle", {31'd0, stall}, 32'd0);
    hazard(5'd0, 5'd0, 5'd0);
    step();
    chk("lu_x0", {31'd0, stall}, 32'd0);
    hazard(5'd5, 5'd6, 5'd7);
    step();
    chk("lu_nomatch", {31'd0, stall}, 32'd0);
    hazard(5'd3, 5'd9, 5'd3);
    step();
    chk("lu_rs1_stall", {31'd0, stall}, 32'd1);
    idle();
    step();
    chk("lu_rs1_rel", {31'd0, stall}, 32'd0);

    // redirect: one update_pc pulse, then two cycles with hazards ignored
    br_taken  = 1'b1;
    br_target = 32'h100;
    step();
    chk("br_upd", {31'd0, update_pc}, 32'd1);
    chk("br_newpc", new_pc, 32'h100);
    chk("br_stall", {31'd0, stall}, 32'd0);
    idle();
    hazard(5'd1, 5'd5, 5'd5);
    step();
    chk("fl1_upd", {31'd0, update_pc}, 32'd0);
    chk("fl1_stall", {31'd0, stall}, 32'd0);
    chk("fl1_hold", new_pc, 32'h100);
    step();
    chk("fl2_stall", {31'd0, stall}, 32'd0);
    step();
    chk("fl_done_haz", {31'd0, stall}, 32'd1);
    idle();
    step();

    // redirect arriving during flush restarts it with the new target
    br_taken  = 1'b1;
    br_target = 32'h200;
    step();
    br_target = 32'h300;
    step();
    chk("rest_upd", {31'd0, update_pc}, 32'd1);
    chk("rest_newpc", new_pc, 32'h300);
    idle();
    hazard(5'd1, 5'd5, 5'd5);
    step();
    chk("rest_fl1", {31'd0, stall}, 32'd0);
    step();
    chk("rest_fl2", {31'd0, stall}, 32'd0);
    step();
    chk("rest_haz", {31'd0, stall}, 32'd1);
    idle();
    step();

    // branch coincident with mem_wait: latched, later branch ignored
    mem_wait  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h400;
    step();
    chk("mw1_stall", {31'd0, stall}, 32'd1);
    chk("mw1_upd", {31'd0, update_pc}, 32'd0);
    br_target = 32'h500;
    step();
    chk("mw2_stall", {31'd0, stall}, 32'd1);
    br_taken = 1'b0;
    step();
    chk("mw3_stall", {31'd0, stall}, 32'd1);
    chk("mw3_newpc", new_pc, 32'h300);
    mem_wait = 1'b0;
    step();
    chk("mw_exit_upd", {31'd0, update_pc}, 32'd1);
    chk("mw_exit_pc", new_pc, 32'h400);
    chk("mw_exit_stall", {31'd0, stall}, 32'd0);
    step();
    step();
    step();
    chk("mw_after_upd", {31'd0, update_pc}, 32'd0);

    // timeout after four MEMW cycles; pending redirect discarded
    mem_wait  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h600;
    for (int i = 0; i < 4; i++) begin
      step();
      br_taken = 1'b0;
      chk($sformatf("to_memw%0d", i), {30'd0, stall, mem_timeout}, 32'd2);
    end
    step();
    chk("to_pulse", {31'd0, mem_timeout}, 32'd1);
    chk("to_upd", {31'd0, update_pc}, 32'd1);
    chk("to_newpc", new_pc, 32'h40);
    chk("to_stall", {31'd0, stall}, 32'd0);
    step();
    chk("to_once", {31'd0, mem_timeout}, 32'd0);
    chk("to_fl_stall", {31'd0, stall}, 32'd0);
    step();
    step();
    chk("to_blk_stall", {31'd0, stall}, 32'd0);
    chk("to_no_pend", {31'd0, update_pc}, 32'd0);
    chk("to_pc_hold", new_pc, 32'h40);
    mem_wait = 1'b0;
    step();
    mem_wait = 1'b1;
    step();
    chk("to_rearm", {31'd0, stall}, 32'd1);
    mem_wait = 1'b0;
    step();
    chk("to_rearm_rel", {31'd0, stall}, 32'd0);

    // reset mid-MEMW with a pending redirect
    mem_wait  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h700;
    step();
    br_taken = 1'b0;
    step();
    chk("rm_pre_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    step();
    chk("rm_outs", {29'd0, stall, update_pc, mem_timeout}, 32'd0);
    chk("rm_newpc", new_pc, 32'd0);
    reset = 1'b0;
    idle();
    step();
    chk("rm_no_upd1", {31'd0, update_pc}, 32'd0);
    step();
    chk("rm_no_upd2", {31'd0, update_pc}, 32'd0);
    chk("rm_pc_zero", new_pc, 32'd0);

    // statistics: 10 stall cycles, 2 redirects since reset
    mem_wait  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h800;
    step();
    br_taken = 1'b0;
    step();
    step();
    mem_wait = 1'b0;
    step();
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      mem_wait = 1'b1;
      step();
      step();
      step();
      mem_wait = 1'b0;
      step();
    end
    hazard(5'd2, 5'd4, 5'd4);
    step();
    idle();
    step();
    br_taken  = 1'b1;
    br_target = 32'h900;
    step();
    idle();
    step();
    step();
    step();
    chk("st_stalls", stall_cycles, EXP_STALLS);
    chk("st_redir", redirect_count, EXP_REDIR);
    chk("st_newpc", new_pc, 32'h900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
